truth_table_sequencer: RTL and testbench

Sequencer that exercises a 2-input combinational gate network (such as the lab's NAND/XOR/NOR cells). On a start request it drives the network's two inputs through all four combinations, waits a programmable settle time per vector, and captures the output into a 4-bit truth table. It then compares the table against an expected pattern and reports pass/fail with a done pulse. The block sits between the testbench or top-level control and any 2-input gate module under test.

---
 rtl/truth_table_sequencer_if.sv | 33 +++
 rtl/truth_table_sequencer.sv | 143 ++++++++++++++
 tb/tb_truth_table_sequencer.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/truth_table_sequencer_if.sv
// Bundle of signals between a truth-table sequencer, its controller and the
// 2-input gate network it exercises.
//   start      controller -> sequencer : sweep request (only honoured in IDLE)
//   expected   controller -> sequencer : expected table, index {a,b}, a = MSB
//   dut_y      gate       -> sequencer : output of the network under test
//   dut_a/b    sequencer  -> gate      : network inputs
//   busy       sequencer  -> controller: sweep in progress
//   done       sequencer  -> controller: one-cycle completion pulse
//   table_out  sequencer  -> controller: captured truth table
//   pass       sequencer  -> controller: table matched expected
//   err_cnt    sequencer  -> controller: number of mismatching bits
interface truth_table_sequencer_if;
    logic       start;
    logic [3:0] expected;
    logic       dut_y;
    logic       dut_a;
    logic       dut_b;
    logic       busy;
    logic       done;
    logic [3:0] table_out;
    logic       pass;
    logic [2:0] err_cnt;

    modport master (
        output start, expected, dut_y,
        input  dut_a, dut_b, busy, done, table_out, pass, err_cnt
    );

    modport slave (
        input  start, expected, dut_y,
        output dut_a, dut_b, busy, done, table_out, pass, err_cnt
    );
endinterface

// File: rtl/truth_table_sequencer.sv
// Truth-table sequencer: on start, walks a 2-input gate network through the
// input vectors 00, 01, 10, 11, holds each vector SETTLE cycles plus one
// sample cycle, captures the network output per vector and finally compares
// the table with the expected pattern latched at start.
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    slave side of truth_table_sequencer_if (see interface header)
// Parameter:
//   SETTLE drive cycles per vector before the sample cycle, legal 1..15
module truth_table_sequencer #(
    parameter int SETTLE = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    truth_table_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    // Number of set bits in a 4-bit vector.
    function automatic logic [2:0] popcount4(input logic [3:0] v);
        popcount4 = {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
    endfunction

    state_t     state_r;
    logic [1:0] idx_r;
    logic [3:0] cnt_r;
    logic [3:0] exp_q_r;
    logic       dut_a_r;
    logic       dut_b_r;
    logic       busy_r;
    logic       done_r;
    logic [3:0] table_out_r;
    logic       pass_r;
    logic [2:0] err_cnt_r;

    // Final table as it will stand after the last sample: the live dut_y
    // supplies bit 3, which is not yet written into table_out_r.
    logic [3:0] final_table_s;
    logic [3:0] mismatch_s;

    assign final_table_s = {bus.dut_y, table_out_r[2:0]};
    assign mismatch_s    = final_table_s ^ exp_q_r;

    // Sequencer FSM; all outputs are registered and set on state entry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            idx_r       <= 2'd0;
            cnt_r       <= 4'd0;
            exp_q_r     <= 4'd0;
            dut_a_r     <= 1'b0;
            dut_b_r     <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            table_out_r <= 4'd0;
            pass_r      <= 1'b0;
            err_cnt_r   <= 3'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    dut_a_r <= 1'b0;
                    dut_b_r <= 1'b0;
                    done_r  <= 1'b0;
                    if (bus.start) begin
                        exp_q_r     <= bus.expected;
                        table_out_r <= 4'd0;
                        pass_r      <= 1'b0;
                        err_cnt_r   <= 3'd0;
                        idx_r       <= 2'd0;
                        cnt_r       <= 4'd0;
                        busy_r      <= 1'b1;
                        state_r     <= ST_DRIVE;
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end

                ST_DRIVE: begin
                    cnt_r <= cnt_r + 4'd1;
                    if (cnt_r == SETTLE_LAST) begin
                        state_r <= ST_SAMPLE;
                    end else begin
                        state_r <= ST_DRIVE;
                    end
                end

                ST_SAMPLE: begin
                    table_out_r[idx_r] <= bus.dut_y;
                    if (idx_r == 2'd3) begin
                        // Last vector: the verdict uses the live sample.
                        pass_r    <= (mismatch_s == 4'd0);
                        err_cnt_r <= popcount4(mismatch_s);
                        busy_r    <= 1'b0;
                        done_r    <= 1'b1;
                        dut_a_r   <= 1'b0;
                        dut_b_r   <= 1'b0;
                        state_r   <= ST_FINISH;
                    end else begin
                        idx_r              <= idx_r + 2'd1;
                        {dut_a_r, dut_b_r} <= idx_r + 2'd1;
                        cnt_r              <= 4'd0;
                        state_r            <= ST_DRIVE;
                    end
                end

                ST_FINISH: begin
                    // start is deliberately not looked at here.
                    done_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end

                default: begin
                    state_r <= ST_IDLE;
                    idx_r   <= 2'd0;
                    cnt_r   <= 4'd0;
                    dut_a_r <= 1'b0;
                    dut_b_r <= 1'b0;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.dut_a     = dut_a_r;
    assign bus.dut_b     = dut_b_r;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.table_out = table_out_r;
    assign bus.pass      = pass_r;
    assign bus.err_cnt   = err_cnt_r;

endmodule

// File: tb/tb_truth_table_sequencer.sv
module tb_truth_table_sequencer;

    typedef struct packed {
        logic [3:0] tbl;
        logic       pass;
        logic [2:0] err;
    } res_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [1:0] mode0;
    logic [1:0] mode1;
    int         errors = 0;
    int         checks = 0;
    res_t       q0[$];
    res_t       q1[$];

    truth_table_sequencer_if bus0();
    truth_table_sequencer_if bus1();

    truth_table_sequencer #(.SETTLE(2)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));
    truth_table_sequencer #(.SETTLE(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

    // Gate network models: 0 = NAND(XOR, NOR(~a,~b)), 1 = XOR, else tied low.
    function automatic logic gate(input logic [1:0] m, input logic a, input logic b);
        case (m)
            2'd0:    return ~((a ^ b) & ~(~a | ~b));
            2'd1:    return a ^ b;
            default: return 1'b0;
        endcase
    endfunction

    assign bus0.dut_y = gate(mode0, bus0.dut_a, bus0.dut_b);
    assign bus1.dut_y = gate(mode1, bus1.dut_a, bus1.dut_b);

    function automatic res_t predict(input logic [3:0] exp, input logic [1:0] m);
        res_t r;
        logic [1:0] kk;
        int n;
        n = 0;
        for (int k = 0; k < 4; k++) begin
            kk = 2'(k);
            r.tbl[k] = gate(m, kk[1], kk[0]);
            if (r.tbl[k] != exp[k]) n++;
        end
        r.pass = (r.tbl == exp);
        r.err  = 3'(n);
        return r;
    endfunction

    // Per-cycle trace of instance 0 (cycle 0 = first cycle after start edge).
    logic [1:0] tr_ab   [64];
    logic       tr_busy [64];
    logic       tr_done [64];
    logic       tr_pass [64];
    logic [2:0] tr_err  [64];
    logic [3:0] tr_tbl  [64];
    int         done_seen;
    int         done_c;
    res_t       cap;

    task automatic start0(input logic [3:0] exp, input logic [1:0] m, input bit push);
        @(negedge clk);
        mode0 = m;
        bus0.start = 1'b1;
        bus0.expected = exp;
        if (push) q0.push_back(predict(exp, m));
    endtask

    // Observe n cycles; pulse start (with a bogus pattern) where smask is set
    // and assert reset during cycle rst_c.
    task automatic watch0(input int n, input logic [63:0] smask, input int rst_c);
        done_seen = 0;
        done_c = -1;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            tr_ab[c]   = {bus0.dut_a, bus0.dut_b};
            tr_busy[c] = bus0.busy;
            tr_done[c] = bus0.done;
            tr_pass[c] = bus0.pass;
            tr_err[c]  = bus0.err_cnt;
            tr_tbl[c]  = bus0.table_out;
            if (bus0.done) begin
                if (done_seen == 0) begin
                    done_c = c;
                    cap.tbl = bus0.table_out;
                    cap.pass = bus0.pass;
                    cap.err = bus0.err_cnt;
                end
                done_seen++;
            end
            bus0.start = smask[c];
            if (smask[c]) bus0.expected = 4'b0000;
            rst_n = (c == rst_c) ? 1'b0 : 1'b1;
        end
        bus0.start = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus0.dut_a, bus0.dut_b, bus0.busy, bus0.done, bus0.pass} !== 5'b0 ||
            bus0.table_out !== 4'd0 || bus0.err_cnt !== 3'd0) begin
            errors++;
            $display("FAIL reset0: ab=%b%b busy=%b done=%b pass=%b tbl=%b err=%0d required all 0",
                     bus0.dut_a, bus0.dut_b, bus0.busy, bus0.done, bus0.pass, bus0.table_out, bus0.err_cnt);
        end
        checks++;
        if ({bus1.dut_a, bus1.dut_b, bus1.busy, bus1.done, bus1.pass} !== 5'b0 ||
            bus1.table_out !== 4'd0 || bus1.err_cnt !== 3'd0) begin
            errors++;
            $display("FAIL reset1: busy=%b done=%b pass=%b tbl=%b err=%0d required all 0",
                     bus1.busy, bus1.done, bus1.pass, bus1.table_out, bus1.err_cnt);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_network;
        res_t r;
        start0(4'b1111, 2'd0, 1'b1);
        watch0(16, 64'd0, -1);
        r = q0.pop_front();
        checks++;
        if (done_seen != 1 || done_c != 12) begin
            errors++;
            $display("FAIL net_done: pulses=%0d cycle=%0d required 1 pulse at 12", done_seen, done_c);
        end
        checks++;
        if (cap !== r) begin
            errors++;
            $display("FAIL net_result: tbl=%b pass=%b err=%0d required tbl=%b pass=%b err=%0d",
                     cap.tbl, cap.pass, cap.err, r.tbl, r.pass, r.err);
        end
    endtask

    task automatic test_xor_vectors;
        res_t r;
        logic [1:0] want;
        start0(4'b0110, 2'd1, 1'b1);
        watch0(16, 64'd0, -1);
        r = q0.pop_front();
        checks++;
        if (done_c != 12 || cap !== r) begin
            errors++;
            $display("FAIL xor_result: cycle=%0d tbl=%b pass=%b err=%0d required cycle=12 tbl=%b pass=%b err=%0d",
                     done_c, cap.tbl, cap.pass, cap.err, r.tbl, r.pass, r.err);
        end
        for (int c = 0; c < 12; c++) begin
            want = 2'(c / 3);
            checks++;
            if (tr_ab[c] !== want || tr_busy[c] !== 1'b1) begin
                errors++;
                $display("FAIL xor_vector c%0d: ab=%b busy=%b required ab=%b busy=1", c, tr_ab[c], tr_busy[c], want);
            end
        end
        checks++;
        if (tr_busy[12] !== 1'b0 || tr_ab[12] !== 2'b00) begin
            errors++;
            $display("FAIL xor_finish: busy=%b ab=%b required 0 00", tr_busy[12], tr_ab[12]);
        end
    endtask

    task automatic test_tied_low;
        res_t r;
        start0(4'b1111, 2'd2, 1'b1);
        watch0(20, 64'd0, -1);
        r = q0.pop_front();
        checks++;
        if (done_c != 12 || cap !== r || r.err !== 3'd4) begin
            errors++;
            $display("FAIL low_result: cycle=%0d tbl=%b pass=%b err=%0d required cycle=12 tbl=%b pass=%b err=%0d",
                     done_c, cap.tbl, cap.pass, cap.err, r.tbl, r.pass, r.err);
        end
        for (int c = 13; c < 20; c++) begin
            checks++;
            if (tr_pass[c] !== 1'b0 || tr_err[c] !== 3'd4) begin
                errors++;
                $display("FAIL low_hold c%0d: pass=%b err=%0d required 0 4", c, tr_pass[c], tr_err[c]);
            end
        end
        // Next start clears the verdict, then a good sweep passes.
        start0(4'b1111, 2'd0, 1'b1);
        watch0(16, 64'd0, -1);
        r = q0.pop_front();
        checks++;
        if (tr_pass[0] !== 1'b0 || tr_err[0] !== 3'd0 || tr_tbl[0] !== 4'd0) begin
            errors++;
            $display("FAIL low_clear: pass=%b err=%0d tbl=%b required 0 0 0000", tr_pass[0], tr_err[0], tr_tbl[0]);
        end
        checks++;
        if (cap !== r) begin
            errors++;
            $display("FAIL low_next: tbl=%b pass=%b required tbl=%b pass=%b", cap.tbl, cap.pass, r.tbl, r.pass);
        end
    endtask

    task automatic test_ignore_start;
        res_t r;
        logic [63:0] m;
        m = 64'd0;
        m[1] = 1'b1;
        m[5] = 1'b1;
        m[12] = 1'b1;
        start0(4'b1111, 2'd0, 1'b1);
        watch0(24, m, -1);
        r = q0.pop_front();
        checks++;
        if (done_seen != 1 || done_c != 12) begin
            errors++;
            $display("FAIL ign_done: pulses=%0d cycle=%0d required 1 at 12", done_seen, done_c);
        end
        checks++;
        if (cap !== r) begin
            errors++;
            $display("FAIL ign_result: tbl=%b pass=%b err=%0d required tbl=%b pass=%b err=%0d",
                     cap.tbl, cap.pass, cap.err, r.tbl, r.pass, r.err);
        end
        for (int c = 13; c < 24; c++) begin
            checks++;
            if (tr_busy[c] !== 1'b0) begin
                errors++;
                $display("FAIL ign_idle c%0d: busy=%b required 0", c, tr_busy[c]);
            end
        end
    endtask

    task automatic test_reset_mid;
        res_t r;
        start0(4'b1111, 2'd0, 1'b0);
        watch0(20, 64'd0, 6);
        checks++;
        if (tr_tbl[6] !== 4'b0011) begin
            errors++;
            $display("FAIL mid_partial: tbl=%b required 0011", tr_tbl[6]);
        end
        checks++;
        if (tr_busy[7] !== 1'b0 || tr_ab[7] !== 2'b00 || tr_done[7] !== 1'b0 ||
            tr_pass[7] !== 1'b0 || tr_tbl[7] !== 4'd0 || tr_err[7] !== 3'd0) begin
            errors++;
            $display("FAIL mid_reset: busy=%b ab=%b done=%b pass=%b tbl=%b err=%0d required all 0",
                     tr_busy[7], tr_ab[7], tr_done[7], tr_pass[7], tr_tbl[7], tr_err[7]);
        end
        checks++;
        if (done_seen != 0) begin
            errors++;
            $display("FAIL mid_nodone: pulses=%0d required 0", done_seen);
        end
        start0(4'b0110, 2'd1, 1'b1);
        watch0(16, 64'd0, -1);
        r = q0.pop_front();
        checks++;
        if (done_c != 12 || cap !== r) begin
            errors++;
            $display("FAIL mid_after: cycle=%0d tbl=%b pass=%b required cycle=12 tbl=%b pass=%b",
                     done_c, cap.tbl, cap.pass, r.tbl, r.pass);
        end
    endtask

    task automatic test_back_to_back;
        res_t r;
        int   nd;
        int   dc[2];
        logic busy9;
        logic busy10;
        nd = 0;
        busy9 = 1'b1;
        busy10 = 1'b0;
        mode1 = 2'd1;
        q1.push_back(predict(4'b0110, 2'd1));
        q1.push_back(predict(4'b1001, 2'd1));
        @(negedge clk);
        bus1.start = 1'b1;
        bus1.expected = 4'b0110;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (c == 9) busy9 = bus1.busy;
            if (c == 10) busy10 = bus1.busy;
            if (bus1.done) begin
                if (nd < 2) dc[nd] = c;
                nd++;
                checks++;
                if (q1.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_extra: unexpected done in cycle %0d", c);
                end else begin
                    r = q1.pop_front();
                    if (bus1.table_out !== r.tbl || bus1.pass !== r.pass || bus1.err_cnt !== r.err) begin
                        errors++;
                        $display("FAIL b2b_result: tbl=%b pass=%b err=%0d required tbl=%b pass=%b err=%0d",
                                 bus1.table_out, bus1.pass, bus1.err_cnt, r.tbl, r.pass, r.err);
                    end
                end
            end
            bus1.start = (c <= 9) ? 1'b1 : 1'b0;
            if (c >= 1) bus1.expected = 4'b1001;
        end
        bus1.start = 1'b0;
        checks++;
        if (nd != 2 || dc[0] != 8 || dc[1] != 18) begin
            errors++;
            $display("FAIL b2b_timing: pulses=%0d first=%0d second=%0d required 2 at 8 and 18", nd, dc[0], dc[1]);
        end
        checks++;
        if (busy9 !== 1'b0 || busy10 !== 1'b1) begin
            errors++;
            $display("FAIL b2b_accept: busy9=%b busy10=%b required 0 1", busy9, busy10);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        mode0 = 2'd0;
        mode1 = 2'd1;
        bus0.start = 1'b0;
        bus0.expected = 4'd0;
        bus1.start = 1'b0;
        bus1.expected = 4'd0;
        test_reset();
        test_network();
        test_xor_vectors();
        test_tied_low();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
